// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared constants for the elevator call-handling blocks.
//   FLOORS_DEF   : default number of served floors
//   DEBOUNCE_DEF : default debounce length in clock cycles
//   FLOOR_W      : floor-index width for the default floor count
//   DB_CNT_W     : debounce counter width (covers DEBOUNCE_CYCLES up to 255)
// -----------------------------------------------------------------------------
package elevator_pkg;

  localparam int FLOORS_DEF   = 8;
  localparam int DEBOUNCE_DEF = 4;
  localparam int FLOOR_W      = $clog2(FLOORS_DEF);
  localparam int DB_CNT_W     = 8;

endpackage : elevator_pkg

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw, asynchronous push button: 2-flop synchroniser, debounce
// counter, and rising-edge detector on the debounced level.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   raw    : raw button input (asynchronous)
//   press  : one-cycle pulse on each 0->1 transition of the debounced level
// The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles in
// which the synchronised value differs from it; any agreeing cycle restarts
// the count.
// -----------------------------------------------------------------------------
module btn_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic                level;
  logic                level_q;
  logic [DB_CNT_W-1:0] cnt;

  // NOTE: the synchroniser flops are reset along with the counter so that a
  // button held through reset is treated as a fresh press after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its neighbour, giving a true two-stage shift.
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_q;

endmodule : btn_debounce

// File: rtl/call_latch.sv
// -----------------------------------------------------------------------------
// call_latch
// Latches elevator calls from cabin and hall buttons and summarises them
// relative to the current cabin floor.
// Ports:
//   clk, reset                 : clock; asynchronous active-low reset
//   btn_cab/btn_up/btn_down    : raw buttons, one bit per floor
//   block                      : per-floor mask discarding new presses
//   clr_cab/clr_up/clr_down    : one-cycle serve pulses clearing calls
//   cur_floor                  : current cabin floor index
//   cab_calls/up_calls/down_calls : latched pending calls
//   call_above/below/here      : any call above / below / at cur_floor
//   call_count                 : number of pending calls in all vectors
// Build option: define CALL_LATCH_CANCEL_EN to let a new cab press toggle an
// already latched cab call off (hall calls are never toggled).
// Timing: raw button to call bit is DEBOUNCE_CYCLES+3 cycles; summaries lag
// the call vectors by one cycle.
// -----------------------------------------------------------------------------
module call_latch
  import elevator_pkg::*;
#(
  parameter int FLOORS          = FLOORS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [FLOORS-1:0]                btn_cab,
  input  logic [FLOORS-1:0]                btn_up,
  input  logic [FLOORS-1:0]                btn_down,
  input  logic [FLOORS-1:0]                block,
  input  logic [FLOORS-1:0]                clr_cab,
  input  logic [FLOORS-1:0]                clr_up,
  input  logic [FLOORS-1:0]                clr_down,
  input  logic [$clog2(FLOORS)-1:0]        cur_floor,
  output logic [FLOORS-1:0]                cab_calls,
  output logic [FLOORS-1:0]                up_calls,
  output logic [FLOORS-1:0]                down_calls,
  output logic                             call_above,
  output logic                             call_below,
  output logic                             call_here,
  output logic [$clog2(3*FLOORS+1)-1:0]    call_count
);

  localparam int CW = $clog2(3*FLOORS+1);

  // No up call exists at the top floor and no down call at the bottom floor.
  localparam logic [FLOORS-1:0] UP_MASK   = {FLOORS{1'b1}} >> 1;
  localparam logic [FLOORS-1:0] DOWN_MASK = {FLOORS{1'b1}} << 1;

  logic [FLOORS-1:0] cab_evt, up_evt, down_evt;
  logic [FLOORS-1:0] cab_nxt, up_nxt, down_nxt;
  logic              above_nxt, below_nxt, here_nxt;
  logic [CW-1:0]     count_nxt;
  logic [FLOORS-1:0] any_call;
  int                cf;

  for (genvar f = 0; f < FLOORS; f++) begin : g_floor
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cab (
      .clk(clk), .rst_n(reset), .raw(btn_cab[f]),  .press(cab_evt[f])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(clk), .rst_n(reset), .raw(btn_up[f]),   .press(up_evt[f])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(clk), .rst_n(reset), .raw(btn_down[f]), .press(down_evt[f])
    );
  end

  // Clear wins over a same-cycle press; a blocked press is simply dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    cab_nxt  = cab_calls;
    up_nxt   = up_calls;
    down_nxt = down_calls;
    for (int f = 0; f < FLOORS; f++) begin
      if (clr_cab[f]) begin
        cab_nxt[f] = 1'b0;
      end else if (cab_evt[f] && !block[f]) begin
`ifdef CALL_LATCH_CANCEL_EN
        cab_nxt[f] = ~cab_calls[f];
`else
        cab_nxt[f] = 1'b1;
`endif
      end
      if (clr_up[f]) begin
        up_nxt[f] = 1'b0;
      end else if (up_evt[f] && !block[f]) begin
        up_nxt[f] = 1'b1;
      end
      if (clr_down[f]) begin
        down_nxt[f] = 1'b0;
      end else if (down_evt[f] && !block[f]) begin
        down_nxt[f] = 1'b1;
      end
    end
  end

  // Summaries from the registered call vectors; an out-of-range floor index
  // reports no calls anywhere.
  always_comb begin
    any_call  = cab_calls | up_calls | down_calls;
    above_nxt = 1'b0;
    below_nxt = 1'b0;
    here_nxt  = 1'b0;
    count_nxt = '0;
    cf        = int'(cur_floor);
    for (int f = 0; f < FLOORS; f++) begin
      count_nxt = count_nxt + CW'(cab_calls[f]) + CW'(up_calls[f])
                + CW'(down_calls[f]);
      if (cf < FLOORS) begin
        if (f > cf) above_nxt = above_nxt | any_call[f];
        if (f < cf) below_nxt = below_nxt | any_call[f];
        if (f == cf) here_nxt = any_call[f];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cab_calls  <= '0;
      up_calls   <= '0;
      down_calls <= '0;
      call_above <= 1'b0;
      call_below <= 1'b0;
      call_here  <= 1'b0;
      call_count <= '0;
    end else begin
      cab_calls  <= cab_nxt;
      up_calls   <= up_nxt & UP_MASK;
      down_calls <= down_nxt & DOWN_MASK;
      call_above <= above_nxt;
      call_below <= below_nxt;
      call_here  <= here_nxt;
      call_count <= count_nxt;
    end
  end

endmodule : call_latch

// File: tb/tb_call_latch.sv
// -----------------------------------------------------------------------------
// tb_call_latch
// Bench for call_latch (FLOORS=8, DEBOUNCE_CYCLES=4). A reference model
// expresses debouncing as "the last DEBOUNCE_CYCLES synchronised samples all
// disagree with the level" over a per-button sample history, and pushes one
// expected output snapshot per clock into a queue; a monitor pops and
// compares on the falling edge. Directed scenarios add fixed-value checks,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_call_latch;
  import elevator_pkg::*;

  localparam int F  = 8;
  localparam int D  = 4;
  localparam int NB = 3*F;
  localparam int CW = $clog2(3*F+1);
`ifdef CALL_LATCH_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  bit                 clk;
  logic               reset;
  logic [F-1:0]       btn_cab, btn_up, btn_down, block;
  logic [F-1:0]       clr_cab, clr_up, clr_down;
  logic [FLOOR_W-1:0] cur_floor;
  logic [F-1:0]       cab_calls, up_calls, down_calls;
  logic               call_above, call_below, call_here;
  logic [CW-1:0]      call_count;

  always #5 clk = ~clk;

  call_latch #(.FLOORS(F), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .btn_cab(btn_cab), .btn_up(btn_up), .btn_down(btn_down), .block(block),
    .clr_cab(clr_cab), .clr_up(clr_up), .clr_down(clr_down),
    .cur_floor(cur_floor),
    .cab_calls(cab_calls), .up_calls(up_calls), .down_calls(down_calls),
    .call_above(call_above), .call_below(call_below), .call_here(call_here),
    .call_count(call_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (reset === 1'b1) cyc <= cyc + 1;
    else                cyc <= 0;
  end

  // ---------------------------------------------------------------- model --
  typedef struct packed {
    logic [F-1:0]  cab;
    logic [F-1:0]  up;
    logic [F-1:0]  down;
    logic          above;
    logic          below;
    logic          here;
    logic [CW-1:0] count;
  } snap_t;

  snap_t exp_q[$];
  bit    hist[NB][$];   // raw samples, oldest first, D+2 deep
  bit    lvl[NB];
  bit    ev[NB];
  bit    mc[3][F];      // model calls: 0 cab, 1 up, 2 down

  function automatic bit raw_of(input int k, input int f);
    case (k)
      0:       return btn_cab[f];
      1:       return btn_up[f];
      default: return btn_down[f];
    endcase
  endfunction

  function automatic bit clr_of(input int k, input int f);
    case (k)
      0:       return clr_cab[f];
      1:       return clr_up[f];
      default: return clr_down[f];
    endcase
  endfunction

  always @(posedge clk) begin
    snap_t        s;
    logic [F-1:0] any_v;
    int           cf;
    int           cnt;
    bit           nv;
    bit           all_opp;
    s = '0;
    if (reset !== 1'b1) begin
      for (int b = 0; b < NB; b++) begin
        hist[b].delete();
        for (int i = 0; i < D+2; i++) hist[b].push_back(1'b0);
        lvl[b] = 1'b0;
        ev[b]  = 1'b0;
      end
      for (int k = 0; k < 3; k++)
        for (int f = 0; f < F; f++) mc[k][f] = 1'b0;
    end else begin
      // Summary reflects the calls held before this edge.
      any_v = '0;
      cnt   = 0;
      for (int k = 0; k < 3; k++)
        for (int f = 0; f < F; f++) begin
          any_v[f] = any_v[f] | mc[k][f];
          cnt      = cnt + int'(mc[k][f]);
        end
      s.count = CW'(cnt);
      cf = int'(cur_floor);
      if (cf < F) begin
        s.here  = any_v[cf];
        s.above = ((32'(any_v) >> (cf + 1)) != 0);
        s.below = ((32'(any_v) & ((32'd1 << cf) - 32'd1)) != 0);
      end
      // Calls take the press events found at the previous edge.
      for (int k = 0; k < 3; k++)
        for (int f = 0; f < F; f++) begin
          nv = mc[k][f];
          if (clr_of(k, f))               nv = 1'b0;
          else if (ev[k*F+f] && !block[f]) nv = (k == 0 && CANCEL) ? !nv : 1'b1;
          if ((k == 1 && f == F-1) || (k == 2 && f == 0)) nv = 1'b0;
          mc[k][f] = nv;
        end
      // Debounce: the debouncer sees the sample taken two edges back.
      for (int k = 0; k < 3; k++)
        for (int f = 0; f < F; f++) begin
          hist[k*F+f].push_back(raw_of(k, f));
          void'(hist[k*F+f].pop_front());
          all_opp = 1'b1;
          for (int i = 0; i < D; i++)
            if (hist[k*F+f][i] == lvl[k*F+f]) all_opp = 1'b0;
          ev[k*F+f] = 1'b0;
          if (all_opp) begin
            lvl[k*F+f] = !lvl[k*F+f];
            ev[k*F+f]  = lvl[k*F+f];
          end
        end
    end
    for (int f = 0; f < F; f++) begin
      s.cab[f]  = mc[0][f];
      s.up[f]   = mc[1][f];
      s.down[f] = mc[2][f];
    end
    exp_q.push_back(s);
  end

  // -------------------------------------------------------------- monitor --
  always @(negedge clk) begin
    snap_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: no expected snapshot, got cab=%0h", cab_calls);
    end else begin
      e = exp_q.pop_front();
      if (reset === 1'b1) begin
        check("sb_cab_calls",  32'(cab_calls),  32'(e.cab));
        check("sb_up_calls",   32'(up_calls),   32'(e.up));
        check("sb_down_calls", 32'(down_calls), 32'(e.down));
        check("sb_flags", 32'({call_above, call_below, call_here}),
              32'({e.above, e.below, e.here}));
        check("sb_call_count", 32'(call_count), 32'(e.count));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cab"},   32'(cab_calls),  32'h0);
    check({tag, "_up"},    32'(up_calls),   32'h0);
    check({tag, "_down"},  32'(down_calls), 32'h0);
    check({tag, "_flags"}, 32'({call_above, call_below, call_here}), 32'h0);
    check({tag, "_count"}, 32'(call_count), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- stimulus --
  initial begin
    reset     = 1'b0;
    btn_cab   = '0;  btn_up = '0;  btn_down = '0;  block = '0;
    clr_cab   = '0;  clr_up = '0;  clr_down = '0;
    cur_floor = '0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b1;

    // Latency: press sampled at edge 11, call at 17, count at 18.
    while (cyc < 10) tick(1);
    btn_cab[2] = 1'b1;
    tick(6);  check("cab2_early", 32'(cab_calls), 32'h00);
    tick(1);  check("cab2_set",   32'(cab_calls), 32'h04);
              check("count_lag",  32'(call_count), 32'd0);
    tick(1);  check("count_one",  32'(call_count), 32'd1);
    btn_cab[2] = 1'b0;  clr_cab[2] = 1'b1;  tick(1);  clr_cab[2] = 1'b0;
    check("cab2_clear", 32'(cab_calls), 32'h00);

    // Glitches shorter than the debounce window never latch.
    btn_up[3] = 1'b1;  tick(3);  btn_up[3] = 1'b0;  tick(1);
    btn_up[3] = 1'b1;  tick(3);  btn_up[3] = 1'b0;  tick(12);
    check("up3_glitch", 32'(up_calls), 32'h00);

    // Press held across block release gives no event; a new press does.
    block = 8'h01;  btn_cab[0] = 1'b1;  tick(10);
    block = 8'h00;  tick(10);
    check("block_held", 32'(cab_calls), 32'h00);
    btn_cab[0] = 1'b0;  tick(10);
    btn_cab[0] = 1'b1;  tick(7);
    check("block_repress", 32'(cab_calls), 32'h01);
    btn_cab[0] = 1'b0;  clr_cab[0] = 1'b1;  tick(1);  clr_cab[0] = 1'b0;

    // Clear in the same cycle as the press event wins; top up / bottom down.
    btn_down[5] = 1'b1;  btn_up[7] = 1'b1;  btn_down[0] = 1'b1;
    tick(6);  clr_down[5] = 1'b1;  tick(1);  clr_down[5] = 1'b0;
    check("down5_clr_wins", 32'(down_calls), 32'h00);
    tick(4);
    check("down5_consumed", 32'(down_calls), 32'h00);
    check("up7_never",      32'(up_calls),   32'h00);
    btn_down[5] = 1'b0;  btn_up[7] = 1'b0;  btn_down[0] = 1'b0;  tick(8);

    // Summary flags relative to cur_floor.
    cur_floor = 3'd3;  btn_cab[0] = 1'b1;  btn_cab[7] = 1'b1;  tick(8);
    btn_cab[0] = 1'b0;  btn_cab[7] = 1'b0;  tick(2);
    check("cab_81",   32'(cab_calls), 32'h81);
    check("flags_f3", 32'({call_above, call_below, call_here}), 32'b110);
    check("count_2",  32'(call_count), 32'd2);
    cur_floor = 3'd7;  tick(1);
    check("flags_f7", 32'({call_above, call_below, call_here}), 32'b011);
    cur_floor = 3'd0;  tick(1);
    check("flags_f0", 32'({call_above, call_below, call_here}), 32'b101);

    // Second press on a latched cab call.
    btn_cab[4] = 1'b1;  tick(8);  btn_cab[4] = 1'b0;  tick(8);
    check("cab4_set", 32'(cab_calls), 32'h91);
    btn_cab[4] = 1'b1;  tick(8);  btn_cab[4] = 1'b0;
    check("cab4_second", 32'(cab_calls), CANCEL ? 32'h81 : 32'h91);
    tick(8);

    // Reset mid-debounce clears outputs at once; held button re-debounces.
    btn_cab[1] = 1'b1;  tick(3);
    reset = 1'b0;  #1;
    check_all_zero("async_reset");
    tick(2);  reset = 1'b1;
    tick(6);  check("rst_hold_early", 32'(cab_calls), 32'h00);
    tick(1);  check("rst_hold_press", 32'(cab_calls), 32'h02);
    btn_cab[1] = 1'b0;  clr_cab[1] = 1'b1;  tick(1);  clr_cab[1] = 1'b0;
    tick(8);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      for (int f = 0; f < F; f++) begin
        if ($urandom_range(11) == 0) btn_cab[f]  = ~btn_cab[f];
        if ($urandom_range(11) == 0) btn_up[f]   = ~btn_up[f];
        if ($urandom_range(11) == 0) btn_down[f] = ~btn_down[f];
        if ($urandom_range(63) == 0) block[f]    = ~block[f];
        clr_cab[f]  = ($urandom_range(31) == 0);
        clr_up[f]   = ($urandom_range(31) == 0);
        clr_down[f] = ($urandom_range(31) == 0);
      end
      if ($urandom_range(7) == 0) cur_floor = FLOOR_W'($urandom_range(F-1));
      tick(1);
    end

    btn_cab = '0;  btn_up = '0;  btn_down = '0;  block = '0;
    clr_cab = '0;  clr_up = '0;  clr_down = '0;
    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_call_latch

// File: doc/call_latch.md
CALL_LATCH -- requirements
Module: call_latch

Interface
REQ-001 SHALL have parameter FLOORS, default 8, number of served floors (2..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before a debounced level changes (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_cab  input  FLOORS  raw in-cabin floor buttons, asynchronous.
REQ-006 SHALL have port btn_up  input  FLOORS  raw hall up buttons, asynchronous.
REQ-007 SHALL have port btn_down  input  FLOORS  raw hall down buttons, asynchronous.
REQ-008 SHALL have port block  input  FLOORS  per-floor press-ignore mask covering all three buttons of that floor.
REQ-009 SHALL have ports clr_cab, clr_up, clr_down  input  FLOORS each  one-cycle serve pulses that clear latched calls.
REQ-010 SHALL have port cur_floor  input  $clog2(FLOORS)  current cabin floor index.
REQ-011 SHALL have ports cab_calls, up_calls, down_calls  output  FLOORS each  latched pending calls.
REQ-012 SHALL have ports call_above, call_below, call_here  output  1 each  any pending call above / below / at cur_floor.
REQ-013 SHALL have port call_count  output  $clog2(3*FLOORS+1)  number of set bits across all three call vectors.

Function
REQ-014 SHALL pass every raw button through a 2-flop synchroniser, then a per-button debounce counter.
REQ-015 SHALL change a debounced level only after DEBOUNCE_CYCLES consecutive cycles of the opposite synchronised value; any glitch restarts the count.
REQ-016 SHALL generate a press event only on a 0->1 transition of the debounced level; a held button produces one event.
REQ-017 SHALL set the call bit on the cycle after a press event; total raw-to-output latency DEBOUNCE_CYCLES+3 cycles.
REQ-018 SHALL discard press events while block[f]=1; calls already latched on floor f stay set; a press held across block deassertion produces no event.
REQ-019 SHALL clear a call bit on the cycle after its clr pulse, regardless of block.
REQ-020 SHALL give clear priority over a same-cycle press event on the same bit; that press is consumed.
REQ-021 SHALL hold up_calls[FLOORS-1] and down_calls[0] at 0 permanently.
REQ-022 SHALL register call_above/call_below/call_here/call_count one cycle after the call vectors they summarise.
REQ-023 SHALL compute call_here from all three vectors at index cur_floor; call_above/call_below from indices strictly greater/less.
REQ-024 SHALL drive all three summary flags to 0 when cur_floor >= FLOORS.

Reset
REQ-025 SHALL, on reset low, asynchronously clear all call vectors, summary flags, call_count, synchronisers, debounced levels and debounce counters to 0.
REQ-026 SHALL discard any debounce in progress at reset; a button held through reset release produces a press after DEBOUNCE_CYCLES+3 cycles.

Configuration
REQ-027 SHALL, with macro CALL_LATCH_CANCEL_EN defined, toggle a latched cab call off on a new cab press event (hall calls unaffected).
REQ-028 SHALL, without CALL_LATCH_CANCEL_EN, ignore press events on already-latched cab calls; clear priority (REQ-020) applies in both builds.

Structure
REQ-029 SHALL place FLOORS default, DEBOUNCE_CYCLES default and the floor-index width constant in shared package elevator_pkg.
REQ-030 SHALL implement synchroniser + debounce + edge detect as sub-module btn_debounce, instantiated 3*FLOORS times.

Verification (FLOORS=8, DEBOUNCE_CYCLES=4)
REQ-031 SHALL check: btn_cab[2] high from cycle 10 -> cab_calls=8'h04 at cycle 17, call_count=1 at cycle 18.
REQ-032 SHALL check: btn_up[3] 3-cycle pulse, low, then 3-cycle pulse -> up_calls stays 0.
REQ-033 SHALL check: block=8'h01, btn_cab[0] held, block released while held -> cab_calls[0] stays 0; release and re-press -> sets.
REQ-034 SHALL check: clr_down[5] in the same cycle as down press event on floor 5 -> down_calls[5]=0 after; btn_up[7] held -> up_calls[7]=0.
REQ-035 SHALL check: cab_calls=8'h81, cur_floor=3 -> call_above=1, call_below=1, call_here=0; cur_floor=7 -> call_here=1, call_above=0.
REQ-036 SHALL check: latched cab_calls[4], second press -> cleared with CALL_LATCH_CANCEL_EN, unchanged without; reset low mid-debounce -> all outputs 0 immediately.
